// File: rtl/signals_pkg.sv
// Shared definitions for the decoded-signal sequencer.
// Holds the two-bit sequencing mode encodings used on the mode input.
package signals_pkg;

    localparam logic [1:0] MODE_UP      = 2'b00;
    localparam logic [1:0] MODE_DOWN    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

endpackage : signals_pkg

// File: rtl/signals_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (prescaler to 0)
//   en    - count enable; the prescaler only advances when high
//   clr   - synchronous clear (driven by the parallel load strobe)
//   tick  - combinational strobe, high on the en cycle where the count is DIV-1
module signals_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // Keep at least one bit of counter so DIV=1 still elaborates cleanly.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + PW'(1);
            end
        end
    end

endmodule : signals_tick_gen

// File: rtl/signals_seq.sv
// Decoded-signal sequencer: steps an index through N_OUT positions and drives
// a registered one-hot of that index, with prescaling, four sequencing modes,
// parallel load, a terminal-event pulse and a sticky one-shot completion flag.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset
//   en         - count enable
//   mode       - 00 UP-wrap, 01 DOWN-wrap, 10 BOUNCE, 11 ONESHOT
//   load       - parallel load strobe (beats any tick on the same edge)
//   load_idx   - index to load, clamped to N_OUT-1
//   dec_signal - registered one-hot of idx
//   idx        - current binary index
//   dir        - 0 = up, 1 = down
//   tc         - one-cycle pulse after a tick that performed a terminal event
//   done       - sticky ONESHOT completion flag
module signals_seq
    import signals_pkg::*;
#(
    parameter  int N_OUT = 16,
    parameter  int DIV   = 1,
    localparam int CW    = $clog2(N_OUT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [CW-1:0]    load_idx,
    output logic [N_OUT-1:0] dec_signal,
    output logic [CW-1:0]    idx,
    output logic             dir,
    output logic             tc,
    output logic             done
);

    localparam logic [CW-1:0] LAST = CW'(N_OUT - 1);

    logic             tick;
    logic [CW-1:0]    idx_n;
    logic             dir_n;
    logic             done_n;
    logic             tc_n;
    logic [N_OUT-1:0] dec_n;

    signals_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    always_comb begin
        idx_n  = idx;
        dir_n  = dir;
        done_n = done;
        tc_n   = 1'b0;
        if (load) begin
            idx_n  = (load_idx > LAST) ? LAST : load_idx;
            dir_n  = (mode == MODE_DOWN);
            done_n = 1'b0;
        end else if (tick) begin
            case (mode)
                MODE_UP: begin
                    dir_n = 1'b0;
                    if (idx == LAST) begin
                        idx_n = '0;
                        tc_n  = 1'b1;
                    end else begin
                        idx_n = idx + CW'(1);
                    end
                end
                MODE_DOWN: begin
                    dir_n = 1'b1;
                    if (idx == '0) begin
                        idx_n = LAST;
                        tc_n  = 1'b1;
                    end else begin
                        idx_n = idx - CW'(1);
                    end
                end
                MODE_BOUNCE: begin
                    // Reflect at the ends rather than dwelling there.
                    if (!dir) begin
                        if (idx == LAST) begin
                            idx_n = LAST - CW'(1);
                            dir_n = 1'b1;
                            tc_n  = 1'b1;
                        end else begin
                            idx_n = idx + CW'(1);
                        end
                    end else begin
                        if (idx == '0) begin
                            idx_n = CW'(1);
                            dir_n = 1'b0;
                            tc_n  = 1'b1;
                        end else begin
                            idx_n = idx - CW'(1);
                        end
                    end
                end
                MODE_ONESHOT: begin
                    dir_n = 1'b0;
                    // Entering at LAST with done clear still completes on
                    // the next tick, so done/tc fire on arrival at LAST.
                    if (!done) begin
                        if (idx < LAST) begin
                            idx_n = idx + CW'(1);
                        end
                        if (idx_n == LAST) begin
                            done_n = 1'b1;
                            tc_n   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Decode the next index so dec_signal and idx update on the same edge.
        dec_n = {{(N_OUT-1){1'b0}}, 1'b1} << idx_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            dec_signal <= {{(N_OUT-1){1'b0}}, 1'b1};
            dir        <= 1'b0;
            tc         <= 1'b0;
            done       <= 1'b0;
        end else begin
            idx        <= idx_n;
            dec_signal <= dec_n;
            dir        <= dir_n;
            tc         <= tc_n;
            done       <= done_n;
        end
    end

endmodule : signals_seq
